menu_nav_ctrl: RTL

// Front-panel navigation stage feeding the top-level app selector. Conditions btnC/btnL/btnR
// (synchronise, debounce, detect release) into one-cycle pulses, runs the menu cursor and

---
 rtl/menu_nav_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/menu_nav_ctrl.sv
// Front-panel navigation: conditions three raw buttons into debounced release pulses and
// runs the menu cursor / app selection state for the top-level app selector.

module menu_nav_debounce #(
  parameter int DEBOUNCE_CYCLES = 6_250_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } db_state_e;

  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pulse_q;
  logic                   btn_s;

  assign btn_s   = sync_q[SYNC_STAGES-1];
  assign pulse_o = pulse_q;

  // Synchroniser chain, debouncer state and the registered release pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= (state_q == ST_FIRE);
    end
  end

  // Release detection: any high sample while armed restarts the low-run count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (btn_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (btn_s) begin
          cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_FIRE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FIRE: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end
endmodule

module menu_nav_ctrl #(
  parameter int DEBOUNCE_CYCLES = 6_250_000,
  parameter int NUM_ITEMS       = 7,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnC,
  input  logic       btnL,
  input  logic       btnR,
  output logic       pulse_c,
  output logic       pulse_l,
  output logic       pulse_r,
  output logic [2:0] machine_state,
  output logic [2:0] menu_state,
  output logic       state_changed
);
  localparam logic [2:0] LAST_ITEM = 3'(NUM_ITEMS);

  logic       pulse_c_s, pulse_l_s, pulse_r_s;
  logic [2:0] machine_q, machine_d;
  logic [2:0] menu_q, menu_d;
  logic       changed_q, changed_d;

  menu_nav_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_c (
    .clock(clock), .reset(reset), .btn_i(btnC), .pulse_o(pulse_c_s));
  menu_nav_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_l (
    .clock(clock), .reset(reset), .btn_i(btnL), .pulse_o(pulse_l_s));
  menu_nav_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_r (
    .clock(clock), .reset(reset), .btn_i(btnR), .pulse_o(pulse_r_s));

  assign pulse_c       = pulse_c_s;
  assign pulse_l       = pulse_l_s;
  assign pulse_r       = pulse_r_s;
  assign machine_state = machine_q;
  assign menu_state    = menu_q;
  assign state_changed = changed_q;

  // Navigation state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      machine_q <= 3'd0;
      menu_q    <= 3'd1;
      changed_q <= 1'b0;
    end else begin
      machine_q <= machine_d;
      menu_q    <= menu_d;
      changed_q <= changed_d;
    end
  end

  // In the menu the centre button launches and wins over L/R; inside an app only L is ours.
  always_comb begin
    machine_d = machine_q;
    menu_d    = menu_q;
    if (machine_q == 3'd0) begin
      if (pulse_c_s) begin
        machine_d = menu_q;
      end else if (pulse_r_s && !pulse_l_s) begin
        menu_d = (menu_q >= LAST_ITEM) ? 3'd1 : menu_q + 3'd1;
      end else if (pulse_l_s && !pulse_r_s) begin
        menu_d = (menu_q <= 3'd1) ? LAST_ITEM : menu_q - 3'd1;
      end else begin
        menu_d = menu_q;
      end
    end else begin
      if (pulse_l_s) begin
        machine_d = 3'd0;
      end else begin
        machine_d = machine_q;
      end
    end
    changed_d = (machine_d != machine_q);
  end
endmodule
